transpose_stream: RTL and testbench
===================================

# transpose_stream

Sequential corner-turn buffer: accepts a block of `ROWS` words of `COLS` bits, one word per handshake, and then emits the transposed block as `COLS` words of `ROWS` bits. Output word `i`, bit `j`, equals input word `j`, bit `i`. The block sits between a row-serial producer and a column-serial consumer, such as bit-sliced operand staging, and is the streaming, handshaked counterpart of the combinational packed/unpacked dimension swap.

## Interface
- `ROWS`, default 4, input words per block; width of each output word; must be ≥1.
- `COLS`, default 8, width of each input word; output words per block; must be ≥1.

- `clk` input, 1 bit, single clock; all state updates on its rising edge.
- `reset` input, 1 bit, synchronous, active-high.
- `in_valid` input, 1 bit, producer has a row on `in_data`.
- `in_ready` output, 1 bit, block accepts a row this cycle.
- `in_data` input, `COLS` bits, row word; bit `i` is column `i`.
- `out_valid` output, 1 bit, `out_data` holds a valid column.
- `out_ready` input, 1 bit, consumer takes the column this cycle.
- `out_data` output, `ROWS` bits, column word; bit `j` comes from row `j`.
- `out_last` output, 1 bit, high with the final column (index `COLS-1`) of a block.

## Operation
- Storage: `ROWS` × `COLS` bit register array, plus a row counter `rcnt` (0..ROWS-1) and a column counter `ccnt` (0..COLS-1). Counter width is max(1, $clog2(N)).
- Two states, `FILL` and `DRAIN`. The buffer is single-banked, so input and output never overlap.
- In `FILL`:
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid && in_ready`, `in_data` is written to row `rcnt`.
  - If `rcnt==ROWS-1`, `rcnt` goes to 0 and the state goes to `DRAIN`; otherwise `rcnt` increments.
  - `in_valid`=0 holds all state.
- In `DRAIN`:
  - `in_ready`=0 and `out_valid`=1.
  - `out_data[j]` = `buf[j][ccnt]` for every `j`. `out_data` is combinational from registers, not from inputs.
  - On `out_valid && out_ready`: if `ccnt==COLS-1`, `ccnt` goes to 0 and the state goes to `FILL`; otherwise `ccnt` increments.
  - `out_ready`=0 holds everything. `out_data` stays stable while stalled.
- `out_last` = `out_valid && (ccnt==COLS-1)`.
- `in_data` is ignored while `in_ready`=0. `out_ready` is ignored while `out_valid`=0.
- The buffer is not cleared between blocks; each new block overwrites every row before it is read.

## Timing
- Reset, while `reset`=1 at a rising edge:
  - state ← `FILL`, `rcnt` ← 0, `ccnt` ← 0, buffer ← 0.
  - The cycle after, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0.
  - `reset` overrides any handshake in the same cycle.
- Reset mid-block, in either state, discards the partial block. No output appears until `ROWS` fresh rows are accepted.
- Fill-to-drain latency: the last row is accepted at edge k. `out_valid`=1 from the cycle after edge k, and column 0 is presented then.
- Drain-to-fill: the last column is taken at edge m. `in_ready`=1 from the cycle after edge m.
- Full throughput, with both sides always ready, is one block per `ROWS+COLS` cycles.
- `ROWS`=1: every accepted row enters `DRAIN`. `COLS`=1: one output per block, with `out_last` high on it.
- Handshakes are registered-state based. There is no combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`.

## Test plan
- Reset state: assert `reset` for 2 cycles with `in_valid`=1 → after release, `in_ready`=1, `out_valid`=0, `out_data`=0, and nothing was captured.
- Basic transpose, `ROWS`=2, `COLS`=5: rows 5'b10000, 5'b11111 → out 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, with `out_last` only on the 5th; `out_valid` rises the cycle after the 2nd row.
- Back-pressure, defaults: rows 8'h01, 8'h02, 8'h04, 8'h08, with `out_ready` toggling randomly → columns 0..3 = 4'h1, 4'h2, 4'h4, 4'h8, and columns 4..7 = 4'h0. `out_data` is stable during stalls and `in_ready`=0 throughout `DRAIN`.
- Input gaps and back-to-back blocks: `in_valid` gapped, two blocks (identity-like 8'hFF, 8'h00, 8'hAA, 8'h55, then its complement) → each drains correctly. `in_ready` rises exactly 1 cycle after the last column, and the second block shows no stale data.
- Reset mid-operation: reset after 2 of 4 rows, and again after 3 of 8 columns → a fresh 4-row block then drains fully, with column 0 first.
- Degenerate sizes: `ROWS`=1, `COLS`=3 with row 3'b101 → out 1, 0, 1. `ROWS`=3, `COLS`=1 with rows 1, 0, 1 → single out 3'b101 with `out_last`=1.

Source files
------------

// File: rtl/transpose_stream.sv
// Corner-turn buffer: takes ROWS words of COLS bits and returns
// the transposed block as COLS words of ROWS bits.
module transpose_stream #(
  parameter int ROWS = 4,
  parameter int COLS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [COLS-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ROWS-1:0] out_data,
  output logic            out_last
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] RLAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] CLAST = CW'(COLS - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                     state;
  state_t                     state_next;
  logic [RW-1:0]              rcnt;
  logic [CW-1:0]              ccnt;
  logic [ROWS-1:0][COLS-1:0]  mem;
  logic                       in_fire;
  logic                       out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && rcnt == RLAST)
          state_next = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && ccnt == CLAST)
          state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FILL;
      rcnt  <= '0;
      ccnt  <= '0;
      mem   <= '0;
    end else begin
      state <= state_next;
      if (in_fire) begin
        mem[rcnt] <= in_data;
        rcnt      <= (rcnt == RLAST) ? '0 : rcnt + 1'b1;
      end
      if (out_fire)
        ccnt <= (ccnt == CLAST) ? '0 : ccnt + 1'b1;
    end
  end

  // Column select straight from the registered array keeps
  // out_data steady across stalls.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < ROWS; j++)
      out_data[j] = mem[j][ccnt];
  end

  assign out_last = out_valid && (ccnt == CLAST);

endmodule

// File: tb/tb_transpose_stream.sv
// Bench for transpose_stream: four sizes, directed rows,
// queue scoreboard checked by a free-running monitor.
module tb_transpose_stream;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid [4];
  logic       in_ready [4];
  logic [7:0] ind [4];
  logic       out_valid [4];
  logic       out_ready [4];
  logic [3:0] od [4];
  logic       out_last [4];

  logic [3:0] od0;
  logic [1:0] od1;
  logic [0:0] od2;
  logic [2:0] od3;

  logic [4:0] exp_q [4][$];
  logic       stall_prev [4];
  logic [3:0] held [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  transpose_stream #(.ROWS(4), .COLS(8)) u0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(ind[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(od0), .out_last(out_last[0]));

  transpose_stream #(.ROWS(2), .COLS(5)) u1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(ind[1][4:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(od1), .out_last(out_last[1]));

  transpose_stream #(.ROWS(1), .COLS(3)) u2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(ind[2][2:0]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(od2), .out_last(out_last[2]));

  transpose_stream #(.ROWS(3), .COLS(1)) u3 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_data(ind[3][0:0]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_data(od3), .out_last(out_last[3]));

  assign od[0] = od0;
  assign od[1] = {2'b0, od1};
  assign od[2] = {3'b0, od2};
  assign od[3] = {1'b0, od3};

  task automatic check(input string name, input logic [7:0] got,
                       input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, got, want, $time);
    end
  endtask

  // Scoreboard monitor: pops one expectation per column handshake.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (out_valid[k]) begin
        check($sformatf("in_ready_in_drain[%0d]", k),
              8'(in_ready[k]), 8'h0);
        if (stall_prev[k])
          check($sformatf("stall_stable[%0d]", k), 8'(od[k]),
                8'(held[k]));
      end
      if (out_valid[k] && out_ready[k] && !reset) begin
        if (exp_q[k].size() == 0) begin
          check($sformatf("unexpected_col[%0d]", k), 8'(od[k]), 8'hxx);
        end else begin
          logic [4:0] e;
          e = exp_q[k].pop_front();
          check($sformatf("col_data[%0d]", k), 8'(od[k]), 8'(e[3:0]));
          check($sformatf("col_last[%0d]", k), 8'(out_last[k]),
                8'(e[4]));
        end
      end
      stall_prev[k] = out_valid[k] && !out_ready[k] && !reset;
      held[k] = od[k];
    end
  end

  task automatic expect_col(input int k, input logic last,
                            input logic [3:0] d);
    exp_q[k].push_back({last, d});
  endtask

  task automatic send(input int k, input logic [7:0] d, input int gap);
    bit acc;
    int n;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    in_valid[k] = 1'b1;
    ind[k] = d;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready[k];
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check($sformatf("send_timeout[%0d]", k), 8'h0, 8'h1);
    in_valid[k] = 1'b0;
    ind[k] = 8'($urandom);
  endtask

  task automatic filled(input int k);
    @(negedge clk);
    check($sformatf("fill_to_drain[%0d]", k), 8'(out_valid[k]), 8'h1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int k, input int n, input bit rnd,
                       input bit end_chk);
    int c;
    int t;
    c = 0;
    t = 0;
    while (c < n && t < 1000) begin
      out_ready[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid[k] && out_ready[k]) c++;
      @(posedge clk);
      #1;
      t++;
    end
    out_ready[k] = 1'b0;
    if (c < n) check($sformatf("drain_timeout[%0d]", k), 8'(c), 8'(n));
    if (end_chk) begin
      @(negedge clk);
      check($sformatf("drain_to_fill_rdy[%0d]", k), 8'(in_ready[k]), 8'h1);
      check($sformatf("drain_to_fill_vld[%0d]", k), 8'(out_valid[k]), 8'h0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_valid", 8'(out_valid[0]), 8'h0);
    check("mid_reset_ready", 8'(in_ready[0]), 8'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b0;
      ind[k] = 8'h0;
      stall_prev[k] = 1'b0;
      held[k] = 4'h0;
    end
    // Reset with a live producer: nothing may be captured.
    in_valid[0] = 1'b1;
    ind[0] = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 8'(in_ready[0]), 8'h1);
    check("rst_out_valid", 8'(out_valid[0]), 8'h0);
    check("rst_out_data", 8'(od[0]), 8'h0);
    check("rst_out_last", 8'(out_last[0]), 8'h0);
    @(posedge clk);
    #1;

    // 2x5 basic transpose
    for (int i = 0; i < 4; i++) expect_col(1, 1'b0, 4'h2);
    expect_col(1, 1'b1, 4'h3);
    send(1, 8'h10, 0);
    send(1, 8'h1F, 0);
    filled(1);
    drain(1, 5, 1'b0, 1'b1);

    // Default size under random back-pressure
    for (int i = 0; i < 4; i++) expect_col(0, 1'b0, 4'(1 << i));
    for (int i = 4; i < 8; i++) expect_col(0, i == 7, 4'h0);
    send(0, 8'h01, 0);
    send(0, 8'h02, 0);
    send(0, 8'h04, 0);
    send(0, 8'h08, 0);
    filled(0);
    drain(0, 8, 1'b1, 1'b1);

    // Gapped input, two blocks back to back
    for (int i = 0; i < 8; i++) expect_col(0, i == 7, i[0] ? 4'h5 : 4'h9);
    send(0, 8'hFF, 2);
    send(0, 8'h00, 1);
    send(0, 8'hAA, 3);
    send(0, 8'h55, 1);
    filled(0);
    drain(0, 8, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) expect_col(0, i == 7, i[0] ? 4'hA : 4'h6);
    send(0, 8'h00, 0);
    send(0, 8'hFF, 2);
    send(0, 8'h55, 0);
    send(0, 8'hAA, 1);
    filled(0);
    drain(0, 8, 1'b1, 1'b1);

    // Reset after 2 rows, then after 3 columns
    send(0, 8'hAA, 0);
    send(0, 8'hBB, 0);
    pulse_reset();
    expect_col(0, 1'b0, 4'h1);
    expect_col(0, 1'b0, 4'h2);
    expect_col(0, 1'b0, 4'h4);
    send(0, 8'h01, 0);
    send(0, 8'h02, 0);
    send(0, 8'h04, 0);
    send(0, 8'h08, 0);
    filled(0);
    drain(0, 3, 1'b0, 1'b0);
    pulse_reset();
    expect_col(0, 1'b0, 4'h9);
    expect_col(0, 1'b0, 4'h9);
    expect_col(0, 1'b0, 4'h5);
    expect_col(0, 1'b0, 4'h5);
    expect_col(0, 1'b0, 4'h6);
    expect_col(0, 1'b0, 4'h6);
    expect_col(0, 1'b0, 4'hA);
    expect_col(0, 1'b1, 4'hA);
    send(0, 8'h0F, 0);
    send(0, 8'hF0, 0);
    send(0, 8'h3C, 0);
    send(0, 8'hC3, 0);
    filled(0);
    drain(0, 8, 1'b0, 1'b1);

    // ROWS=1, COLS=3
    expect_col(2, 1'b0, 4'h1);
    expect_col(2, 1'b0, 4'h0);
    expect_col(2, 1'b1, 4'h1);
    send(2, 8'h05, 0);
    filled(2);
    drain(2, 3, 1'b0, 1'b1);

    // ROWS=3, COLS=1
    expect_col(3, 1'b1, 4'h5);
    send(3, 8'h01, 0);
    send(3, 8'h00, 1);
    send(3, 8'h01, 0);
    filled(3);
    drain(3, 1, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    for (int k = 0; k < 4; k++)
      check($sformatf("queue_empty[%0d]", k), 8'(exp_q[k].size()), 8'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
